// File: rtl/uart2_tx_core_if.sv
// uart2_tx_core_if: host-side byte handshake of the UART transmitter.
// The host drives the load strobe, the byte and the transmit permit;
// the transmitter answers with the holding-register-empty flag.
interface uart2_tx_core_if;
  logic       ld_tx_data;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       tx_empty;

  modport master (
    output ld_tx_data,
    output tx_data,
    output tx_enable,
    input  tx_empty
  );

  modport slave (
    input  ld_tx_data,
    input  tx_data,
    input  tx_enable,
    output tx_empty
  );
endinterface

// File: rtl/uart2_tx_core.sv
// uart2_tx_core: byte-wide asynchronous serial transmitter, 8 data bits,
// no parity, STOP_BITS stop bits, LSB first. A single holding register is
// loaded while tx_empty is high and stays occupied for the whole frame.
// Dropping tx_enable mid-frame parks the line high and keeps the byte so
// the frame restarts from its start bit once tx_enable returns.
module uart2_tx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  uart2_tx_core_if.slave host,
  output logic           tx_out
);

  // The baud counter has to span the longest segment, which is the stop
  // period (STOP_BITS bit periods); keep at least one bit of width.
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W     = (STOP_CLKS > 1) ? $clog2(STOP_CLKS) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       hold_r;
  logic             empty_r;
  logic             tx_out_r;

  logic             bit_done_s;
  logic             stop_done_s;
  logic             load_s;
  logic             next_bit_s;

  // Segment-end decode, load qualification and the data bit that follows
  // the one currently on the line.
  always_comb begin
    bit_done_s  = (baud_cnt_r == BIT_LAST);
    stop_done_s = (baud_cnt_r == STOP_LAST);
    load_s      = host.ld_tx_data & empty_r;
    if (bit_cnt_r == 3'd7) begin
      next_bit_s = 1'b1;
    end else begin
      next_bit_s = hold_r[bit_cnt_r + 3'd1];
    end
  end

  // Frame sequencer: holding register, empty flag, counters and the
  // registered serial line all advance together on the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= CNT_ZERO;
      bit_cnt_r  <= 3'd0;
      hold_r     <= 8'h00;
      empty_r    <= 1'b1;
      tx_out_r   <= 1'b1;
    end else begin
      // A load is only honoured while the register is free, so a byte in
      // flight is never overwritten. The FSM below never frees the
      // register while it is free, so the two writes cannot collide.
      if (load_s) begin
        hold_r  <= host.tx_data;
        empty_r <= 1'b0;
      end else begin
        hold_r  <= hold_r;
      end

      if (!host.tx_enable) begin
        // Permit withdrawn: abandon the frame, keep the byte.
        state_r    <= IDLE;
        baud_cnt_r <= CNT_ZERO;
        bit_cnt_r  <= 3'd0;
        tx_out_r   <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            baud_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 3'd0;
            // Uses the registered flag: a byte loaded on this edge starts
            // on the next one.
            if (!empty_r) begin
              state_r  <= START;
              tx_out_r <= 1'b0;
            end else begin
              state_r  <= IDLE;
              tx_out_r <= 1'b1;
            end
          end

          START: begin
            if (bit_done_s) begin
              state_r    <= DATA;
              baud_cnt_r <= CNT_ZERO;
              bit_cnt_r  <= 3'd0;
              tx_out_r   <= hold_r[0];
            end else begin
              baud_cnt_r <= baud_cnt_r + CNT_ONE;
              tx_out_r   <= 1'b0;
            end
          end

          DATA: begin
            if (bit_done_s) begin
              baud_cnt_r <= CNT_ZERO;
              if (bit_cnt_r == 3'd7) begin
                state_r   <= STOP;
                bit_cnt_r <= 3'd0;
                tx_out_r  <= 1'b1;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                tx_out_r  <= next_bit_s;
              end
            end else begin
              baud_cnt_r <= baud_cnt_r + CNT_ONE;
            end
          end

          STOP: begin
            tx_out_r <= 1'b1;
            if (stop_done_s) begin
              state_r    <= IDLE;
              baud_cnt_r <= CNT_ZERO;
              empty_r    <= 1'b1;
            end else begin
              baud_cnt_r <= baud_cnt_r + CNT_ONE;
            end
          end

          default: begin
            state_r    <= IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 3'd0;
            tx_out_r   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx_out        = tx_out_r;
  assign host.tx_empty = empty_r;

endmodule

// File: tb/tb_uart2_tx_core.sv
// tb_uart2_tx_core: randomized scoreboard bench for uart2_tx_core.
// Two instances: A with default timing (16 clk/bit, 1 stop bit) and B with
// 4 clk/bit and 2 stop bits. Only the selected instance gets traffic.
module tb_uart2_tx_core;

  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld;
  logic       en;
  logic [7:0] data;
  logic       sel;
  logic       mon_en;
  logic       out_a;
  logic       out_b;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  exp_t       exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart2_tx_core_if if_a ();
  uart2_tx_core_if if_b ();

  assign if_a.ld_tx_data = ld & ~sel;
  assign if_a.tx_data    = data;
  assign if_a.tx_enable  = en & ~sel;
  assign if_b.ld_tx_data = ld & sel;
  assign if_b.tx_data    = data;
  assign if_b.tx_enable  = en & sel;

  uart2_tx_core #(.CLKS_PER_BIT(16), .STOP_BITS(1)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .host   (if_a.slave),
    .tx_out (out_a)
  );

  uart2_tx_core #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .host   (if_b.slave),
    .tx_out (out_b)
  );

  wire cur_line  = sel ? out_b : out_a;
  wire cur_empty = sel ? if_b.tx_empty : if_a.tx_empty;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line level k clocks after the falling edge of the start bit.
  function automatic logic model_bit(input logic [7:0] d, input int k, input int c);
    int idx;
    idx = k / c;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  // Monitor: on every start bit pop the expected byte and follow the frame.
  initial begin : monitor
    exp_t e;
    int   c;
    int   flen;
    forever begin
      @(negedge clk);
      if (mon_en && reset && cur_line === 1'b0) begin
        c    = sel ? 4 : 16;
        flen = (9 + (sel ? 2 : 1)) * c;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame at cycle %0d: start bit with no byte pending", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("start_cycle", cyc, e.start);
          for (int k = 0; k < flen; k++) begin
            if (k > 0) @(negedge clk);
            chk("line_bit", {31'd0, cur_line}, {31'd0, model_bit(e.data, k, c)});
            chk("busy_empty", {31'd0, cur_empty}, 32'd0);
          end
          @(negedge clk);
          chk("empty_after_frame", {31'd0, cur_empty}, 32'd1);
          chk("idle_after_frame", {31'd0, cur_line}, 32'd1);
        end
      end
    end
  end

  // Wait for a free holding register; meanwhile throw ignored loads at it.
  task automatic wait_empty(input int budget);
    int t;
    t = 0;
    while (cur_empty !== 1'b1 && t < budget) begin
      if ($urandom_range(0, 15) == 0) begin
        ld   = 1'b1;
        data = 8'($urandom);
      end else begin
        ld = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    ld = 1'b0;
    if (t >= budget) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_empty_timeout at cycle %0d: tx_empty still %0b", cyc, cur_empty);
    end
  endtask

  task automatic load_byte(input logic [7:0] d, input bit expect_start);
    ld   = 1'b1;
    data = d;
    @(negedge clk);
    ld   = 1'b0;
    data = 8'($urandom);
    if (expect_start) exp_q.push_back('{d, cyc + 1});
  endtask

  task automatic random_frames(input int n, input int budget);
    for (int i = 0; i < n; i++) begin
      wait_empty(budget);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      load_byte(8'($urandom), 1'b1);
    end
  endtask

  initial begin : stimulus
    int t;
    reset  = 1'b0;
    ld     = 1'b0;
    en     = 1'b0;
    data   = 8'h00;
    sel    = 1'b0;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_line_a", {31'd0, out_a}, 32'd1);
    chk("reset_empty_a", {31'd0, if_a.tx_empty}, 32'd1);
    chk("reset_line_b", {31'd0, out_b}, 32'd1);
    chk("reset_empty_b", {31'd0, if_b.tx_empty}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    en     = 1'b1;

    // 0x55 with default framing.
    wait_empty(50);
    load_byte(8'h55, 1'b1);

    // 0xA3, then an explicit 0xFF load attempt mid-frame that must be ignored.
    wait_empty(400);
    load_byte(8'hA3, 1'b1);
    repeat (20) @(negedge clk);
    ld   = 1'b1;
    data = 8'hFF;
    @(negedge clk);
    ld   = 1'b0;

    random_frames(6, 400);

    // Byte loaded while transmission is not permitted.
    wait_empty(400);
    en = 1'b0;
    load_byte(8'h0F, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("held_line", {31'd0, out_a}, 32'd1);
      chk("held_empty", {31'd0, if_a.tx_empty}, 32'd0);
    end
    en = 1'b1;
    exp_q.push_back('{8'h0F, cyc + 1});

    // Abort during data bit 3, then restart the whole frame.
    wait_empty(400);
    mon_en = 1'b0;
    load_byte(8'hC6, 1'b0);
    repeat (1 + 16 * 4 + 5) @(negedge clk);
    chk("abort_pre_bit3", {31'd0, out_a}, 32'd0);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_line", {31'd0, out_a}, 32'd1);
      chk("abort_empty", {31'd0, if_a.tx_empty}, 32'd0);
    end
    mon_en = 1'b1;
    en     = 1'b1;
    exp_q.push_back('{8'hC6, cyc + 1});

    // Asynchronous reset in the middle of a frame.
    wait_empty(400);
    mon_en = 1'b0;
    load_byte(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_line", {31'd0, out_a}, 32'd1);
    chk("rst_mid_empty", {31'd0, if_a.tx_empty}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("post_rst_line", {31'd0, out_a}, 32'd1);
      chk("post_rst_empty", {31'd0, if_a.tx_empty}, 32'd1);
    end
    mon_en = 1'b1;

    // Instance B: 2 stop bits, 4 clk/bit, back-to-back 0x00 then 0xFF.
    sel = 1'b1;
    @(negedge clk);
    wait_empty(100);
    load_byte(8'h00, 1'b1);
    wait_empty(100);
    load_byte(8'hFF, 1'b1);
    random_frames(8, 100);

    // Drain the scoreboard and let the last frame finish.
    t = 0;
    while (exp_q.size() > 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d frames never started", exp_q.size());
    end
    wait_empty(400);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
